// File: rtl/viterbi_conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder feeding the Viterbi decoder.
// Bytes are accepted in IDLE, shifted out MSB first as 2-bit symbols in
// SHIFT, and the last byte of a frame is followed by three zero-input tail
// symbols in TAIL that flush the 3-bit shift register back to zero.
// All outputs are registers loaded from the next-state values, so nothing
// downstream sees a combinational path from sym_ready.
module viterbi_conv_encoder #(
    parameter logic [3:0] G0 = 4'b1111,
    parameter logic [3:0] G1 = 4'b1011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym_data,
    output logic       sym_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] sr_r, sr_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [1:0] tail_cnt_r, tail_cnt_s;
    logic [7:0] byte_r, byte_s;
    logic       last_r, last_s;
    logic       hs_s;
    logic       u_cur_s;
    logic       u_nxt_s;
    logic [1:0] sym_data_s;
    logic       sym_last_s;

    // Even-parity reduction of a 4-bit tap vector.
    function automatic logic parity4(input logic [3:0] v);
        return ^v;
    endfunction

    // One code symbol: bit 0 from G0, bit 1 from G1, taps {u, sr[2:0]}.
    function automatic logic [1:0] encode(input logic u, input logic [2:0] sr);
        logic [3:0] taps;
        taps = {u, sr};
        return {parity4(taps & G1), parity4(taps & G0)};
    endfunction

    // Symbol handshake and the input bit currently on the wire.
    always_comb begin
        hs_s = sym_valid & sym_ready;
        if (state_r == ST_SHIFT) begin
            u_cur_s = byte_r[bit_cnt_r];
        end else begin
            u_cur_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE/SHIFT/TAIL controller and datapath.
    always_comb begin
        state_s    = state_r;
        sr_s       = sr_r;
        bit_cnt_s  = bit_cnt_r;
        tail_cnt_s = tail_cnt_r;
        byte_s     = byte_r;
        last_s     = last_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    byte_s    = in_data;
                    last_s    = in_last;
                    bit_cnt_s = 3'd7;
                    state_s   = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (hs_s) begin
                    sr_s = {u_cur_s, sr_r[2:1]};
                    if (bit_cnt_r == 3'd0) begin
                        if (last_r) begin
                            tail_cnt_s = 2'd2;
                            state_s    = ST_TAIL;
                        end else begin
                            // Mid-frame byte boundary: keep sr for the next byte.
                            state_s = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r - 3'd1;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_TAIL: begin
                if (hs_s) begin
                    if (tail_cnt_r == 2'd0) begin
                        sr_s    = 3'b000;
                        state_s = ST_IDLE;
                    end else begin
                        sr_s       = {1'b0, sr_r[2:1]};
                        tail_cnt_s = tail_cnt_r - 2'd1;
                    end
                end else begin
                    state_s = ST_TAIL;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                sr_s       = 3'b000;
                bit_cnt_s  = 3'd0;
                tail_cnt_s = 2'd0;
            end
        endcase
    end

    // Symbol that will be presented after the coming edge.
    always_comb begin
        sym_data_s = 2'b00;
        sym_last_s = 1'b0;
        u_nxt_s    = 1'b0;
        case (state_s)
            ST_SHIFT: begin
                u_nxt_s    = byte_s[bit_cnt_s];
                sym_data_s = encode(u_nxt_s, sr_s);
                sym_last_s = 1'b0;
            end
            ST_TAIL: begin
                u_nxt_s    = 1'b0;
                sym_data_s = encode(u_nxt_s, sr_s);
                sym_last_s = (tail_cnt_s == 2'd0);
            end
            default: begin
                sym_data_s = 2'b00;
                sym_last_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            sr_r       <= 3'b000;
            bit_cnt_r  <= 3'd0;
            tail_cnt_r <= 2'd0;
            byte_r     <= 8'h00;
            last_r     <= 1'b0;
            sym_valid  <= 1'b0;
            sym_data   <= 2'b00;
            sym_last   <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state_r    <= state_s;
            sr_r       <= sr_s;
            bit_cnt_r  <= bit_cnt_s;
            tail_cnt_r <= tail_cnt_s;
            byte_r     <= byte_s;
            last_r     <= last_s;
            sym_valid  <= (state_s != ST_IDLE);
            sym_data   <= sym_data_s;
            sym_last   <= sym_last_s;
            busy       <= (state_s != ST_IDLE);
            in_ready   <= (state_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_viterbi_conv_encoder.sv
// Self-checking bench for viterbi_conv_encoder: a table of bytes with
// expected symbol/sym_last counts, a scoreboard of expected symbols built by
// a bit-history convolution model, plus hand-written reset and impulse cases.
module tb_viterbi_conv_encoder;

    localparam logic [3:0] G0 = 4'b1111;
    localparam logic [3:0] G1 = 4'b1011;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_data;
    logic       sym_last;
    logic       busy;

    viterbi_conv_encoder #(.G0(G0), .G1(G1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_data(sym_data), .sym_last(sym_last),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] data;
        logic       last;
    } exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] rmode;     // 0: ready high, 1: toggle, 2: random
        logic       hold;      // keep in_valid high with junk data while busy
        logic [7:0] exp_syms;
        logic [1:0] exp_lasts;
    } vec_t;

    exp_t sb_q[$];
    bit   hist_q[$];           // previous input bits, newest at index 0
    int   checks = 0;
    int   errors = 0;
    int   rmode = 0;
    int   sym_count = 0;
    int   last_count = 0;
    int   accept_count = 0;
    int   exp_accepts = 0;
    int   overlap_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        hist_q.delete();
        for (int i = 0; i < 3; i++) hist_q.push_back(1'b0);
    endtask

    task automatic push_bit(input bit u, input bit l);
        logic [3:0] taps;
        exp_t e;
        taps   = {u, hist_q[0], hist_q[1], hist_q[2]};
        e.data = {^(taps & G1), ^(taps & G0)};
        e.last = l;
        sb_q.push_back(e);
        hist_q.push_front(u);
        void'(hist_q.pop_back());
    endtask

    task automatic model_push(input logic [7:0] d, input logic l);
        for (int i = 7; i >= 0; i--) push_bit(d[i], 1'b0);
        if (l) begin
            for (int j = 0; j < 3; j++) push_bit(1'b0, j == 2);
        end
    endtask

    // Backpressure generator on sym_ready.
    initial begin
        sym_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       sym_ready = 1'b1;
                1:       sym_ready = ~sym_ready;
                default: sym_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare every presented symbol with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1) begin
                if (in_valid && in_ready) accept_count++;
                if (in_ready && sym_valid) overlap_count++;
                if (sym_valid) begin
                    if (sb_q.size() == 0) begin
                        check("sym_without_expect", sb_q.size(), 1);
                    end else begin
                        e = sb_q[0];
                        if (sym_ready) begin
                            check("sym_data", sym_data, e.data);
                            check("sym_last", sym_last, e.last);
                            void'(sb_q.pop_front());
                            sym_count++;
                            if (sym_last) last_count++;
                        end else begin
                            check("stall_hold", {sym_data, sym_last}, {e.data, e.last});
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input bit hold, input bit use_model);
        int c;
        @(negedge clk);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        c = 0;
        while (!in_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
        end else begin
            if (use_model) model_push(d, l);
            exp_accepts++;
        end
        @(posedge clk);
        #2;
        if (hold) begin
            for (int k = 0; k < 400 && in_valid; k++) begin
                if (sb_q.size() <= 1) begin
                    in_valid = 1'b0;
                end else begin
                    in_data = 8'($urandom);
                    in_last = 1'($urandom);
                    @(posedge clk);
                    #2;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) break;
        end
        check("drain_busy", busy, 0);
        check("drain_queue", sb_q.size(), 0);
    endtask

    task automatic run_impulse();
        logic [1:0] imp [11];
        exp_t e;
        imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 11; i++) begin
            e.data = imp[i];
            e.last = (i == 10);
            sb_q.push_back(e);
        end
        rmode = 0;
        send_byte(8'h80, 1'b1, 1'b0, 1'b0);
        wait_idle();
    endtask

    vec_t tbl [10];
    int   sc0;
    int   lc0;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 2'd0, 1'b0, 8'd11, 2'd1};
        tbl[1] = '{8'hA5, 1'b1, 2'd1, 1'b0, 8'd11, 2'd1};
        tbl[2] = '{8'h12, 1'b0, 2'd0, 1'b0, 8'd8,  2'd0};
        tbl[3] = '{8'h34, 1'b0, 2'd0, 1'b0, 8'd8,  2'd0};
        tbl[4] = '{8'h56, 1'b1, 2'd0, 1'b0, 8'd11, 2'd1};
        tbl[5] = '{8'hFF, 1'b1, 2'd2, 1'b1, 8'd11, 2'd1};
        tbl[6] = '{8'h00, 1'b1, 2'd0, 1'b0, 8'd11, 2'd1};
        tbl[7] = '{8'h3C, 1'b0, 2'd2, 1'b1, 8'd8,  2'd0};
        tbl[8] = '{8'hC3, 1'b1, 2'd1, 1'b1, 8'd11, 2'd1};
        tbl[9] = '{8'h01, 1'b1, 2'd2, 1'b0, 8'd11, 2'd1};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        model_reset();
        #12;
        check("rst_sym_valid", sym_valid, 0);
        check("rst_sym_data", sym_data, 0);
        check("rst_sym_last", sym_last, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // Impulse response from the reset state.
        run_impulse();

        // Table-driven bytes and frames.
        for (int i = 0; i < 10; i++) begin
            rmode = int'(tbl[i].rmode);
            sc0   = sym_count;
            lc0   = last_count;
            send_byte(tbl[i].data, tbl[i].last, tbl[i].hold, 1'b1);
            wait_idle();
            check("vec_sym_count", sym_count - sc0, 32'(tbl[i].exp_syms));
            check("vec_last_count", last_count - lc0, 32'(tbl[i].exp_lasts));
            check("vec_accepts", accept_count, exp_accepts);
        end

        // Reset while the symbol for bit 4 of a byte is on the wire.
        rmode = 0;
        send_byte(8'h80, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_sym_valid", sym_valid, 0);
        check("midrst_sym_data", sym_data, 0);
        check("midrst_sym_last", sym_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_impulse();

        // Longer random frame under random backpressure.
        rmode = 2;
        sc0   = sym_count;
        lc0   = last_count;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'($urandom), (i == 15), 1'b0, 1'b1);
        end
        wait_idle();
        check("rand_sym_count", sym_count - sc0, 131);
        check("rand_last_count", last_count - lc0, 1);
        check("rand_accepts", accept_count, exp_accepts);
        check("ready_only_idle", overlap_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
